// File: rtl/region_frame_buffer_if.sv
// Pixel write stream from the renderer: AXI-stream data/handshake plus the
// screen coordinate of the pixel being offered.
interface region_frame_buffer_if #(
  parameter int PIXEL_WIDTH = 24
);
  logic [PIXEL_WIDTH-1:0] s_pixel_tdata;
  logic                   s_pixel_tvalid;
  logic                   s_pixel_tready;
  logic [10:0]            s_hcount;
  logic [9:0]             s_vcount;

  modport master (
    output s_pixel_tdata, s_pixel_tvalid, s_hcount, s_vcount,
    input  s_pixel_tready
  );

  modport slave (
    input  s_pixel_tdata, s_pixel_tvalid, s_hcount, s_vcount,
    output s_pixel_tready
  );
endinterface

// File: rtl/region_frame_buffer.sv
// Double-buffered framebuffer for a rectangular render region: the renderer fills
// the back bank while VGA scan-out reads the front bank with a fixed 2-cycle latency.
module region_frame_buffer #(
  parameter int                     START_X       = 260,
  parameter int                     START_Y       = 195,
  parameter int                     END_X         = 390,
  parameter int                     END_Y         = 295,
  parameter int                     PIXEL_WIDTH   = 24,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR      = '0,
  parameter int                     DOUBLE_BUFFER = 1,
  localparam int W     = END_X - START_X,
  localparam int DEPTH = W * (END_Y - START_Y),
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  region_frame_buffer_if.slave   s_pixel,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   active_draw_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   new_frame_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   active_draw_out,
  output logic                   buffer_sel,
  output logic                   frame_done,
  output logic [CW-1:0]          write_count
);

  typedef enum logic {FILL, WAIT_SWAP} state_t;

  state_t                 state_q, state_d;
  logic                   buffer_sel_q, buffer_sel_d;
  logic                   frame_done_q, frame_done_d;
  logic [CW-1:0]          write_count_q, write_count_d;

  logic [AW:0]            rd_addr_q, rd_addr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [2:0]             sync1_q, sync1_d;
  logic [2:0]             sync2_q, sync2_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;

  logic                   wr_in_region;
  logic                   wr_en;
  logic                   back_bank;
  logic [AW-1:0]          wr_offset;
  logic [AW:0]            wr_addr;
  logic                   rd_in_region;
  logic [AW-1:0]          rd_offset;

  // Bank bit is the address MSB; single-bank mode only ever uses bank 0.
  logic [PIXEL_WIDTH-1:0] mem [2**(AW+1)];

  assign s_pixel.s_pixel_tready = (state_q == FILL);
  assign back_bank = (DOUBLE_BUFFER != 0) ? ~buffer_sel_q : 1'b0;

  always_comb begin
    wr_in_region = (int'(s_pixel.s_hcount) >= START_X) && (int'(s_pixel.s_hcount) < END_X) &&
                   (int'(s_pixel.s_vcount) >= START_Y) && (int'(s_pixel.s_vcount) < END_Y);
    wr_offset    = AW'((int'(s_pixel.s_hcount) - START_X) +
                       (int'(s_pixel.s_vcount) - START_Y) * W);
    wr_addr      = {back_bank, wr_offset};
    wr_en        = s_pixel.s_pixel_tvalid && s_pixel.s_pixel_tready && wr_in_region;
  end

  always_comb begin
    state_d       = state_q;
    buffer_sel_d  = buffer_sel_q;
    write_count_d = write_count_q;
    frame_done_d  = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          if (write_count_q == CW'(DEPTH - 1)) begin
            if (DOUBLE_BUFFER != 0) begin
              write_count_d = CW'(DEPTH);
              state_d       = WAIT_SWAP;
            end else begin
              write_count_d = '0;
              frame_done_d  = 1'b1;
            end
          end else begin
            write_count_d = write_count_q + CW'(1);
          end
        end
      end
      WAIT_SWAP: begin
        // new_frame_in is only looked at here, so one coinciding with the
        // completing write is deliberately missed.
        if (new_frame_in) begin
          buffer_sel_d  = ~buffer_sel_q;
          write_count_d = '0;
          frame_done_d  = 1'b1;
          state_d       = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    rd_in_region = (int'(hcount_in) >= START_X) && (int'(hcount_in) < END_X) &&
                   (int'(vcount_in) >= START_Y) && (int'(vcount_in) < END_Y);
    rd_offset    = AW'((int'(hcount_in) - START_X) + (int'(vcount_in) - START_Y) * W);
    // Front bank is captured with the address so a swap cannot split a pixel.
    rd_addr_d    = {buffer_sel_q, rd_offset};
    rd_valid_d   = rd_in_region && active_draw_in;
    sync1_d      = {hsync_in, vsync_in, active_draw_in};
    sync2_d      = sync1_q;
    pixel_d      = rd_valid_q ? mem[rd_addr_q] : BG_COLOR;
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= s_pixel.s_pixel_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= FILL;
      buffer_sel_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      write_count_q <= '0;
      rd_addr_q     <= '0;
      rd_valid_q    <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      pixel_q       <= '0;
    end else begin
      state_q       <= state_d;
      buffer_sel_q  <= buffer_sel_d;
      frame_done_q  <= frame_done_d;
      write_count_q <= write_count_d;
      rd_addr_q     <= rd_addr_d;
      rd_valid_q    <= rd_valid_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      pixel_q       <= pixel_d;
    end
  end

  assign pixel_out       = pixel_q;
  assign hsync_out       = sync2_q[2];
  assign vsync_out       = sync2_q[1];
  assign active_draw_out = sync2_q[0];
  assign buffer_sel      = buffer_sel_q;
  assign frame_done      = frame_done_q;
  assign write_count     = write_count_q;

endmodule

// File: tb/tb_region_frame_buffer.sv
// Directed bench for region_frame_buffer: a double-buffered and a single-bank
// instance over a 4x2 region at (10,5), checked with immediate assertions.
module tb_region_frame_buffer;

  localparam logic [23:0] BG = 24'h123456;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        active_draw_in = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        new_frame_in = 1'b0;

  logic [23:0] db_pixel, sb_pixel;
  logic        db_hs, db_vs, db_ad, db_sel, db_done;
  logic        sb_hs, sb_vs, sb_ad, sb_sel, sb_done;
  logic [3:0]  db_count, sb_count;

  int n_assert = 0;
  int n_fail   = 0;

  region_frame_buffer_if #(.PIXEL_WIDTH(24)) db_if();
  region_frame_buffer_if #(.PIXEL_WIDTH(24)) sb_if();

  always #5 aclk = ~aclk;

  region_frame_buffer #(
    .START_X(10), .START_Y(5), .END_X(14), .END_Y(7),
    .PIXEL_WIDTH(24), .BG_COLOR(BG), .DOUBLE_BUFFER(1)
  ) dut_db (
    .aclk(aclk), .aresetn(aresetn), .s_pixel(db_if),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .active_draw_in(active_draw_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .new_frame_in(new_frame_in),
    .pixel_out(db_pixel), .hsync_out(db_hs), .vsync_out(db_vs),
    .active_draw_out(db_ad), .buffer_sel(db_sel), .frame_done(db_done),
    .write_count(db_count)
  );

  region_frame_buffer #(
    .START_X(10), .START_Y(5), .END_X(14), .END_Y(7),
    .PIXEL_WIDTH(24), .BG_COLOR(BG), .DOUBLE_BUFFER(0)
  ) dut_sb (
    .aclk(aclk), .aresetn(aresetn), .s_pixel(sb_if),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .active_draw_in(active_draw_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .new_frame_in(new_frame_in),
    .pixel_out(sb_pixel), .hsync_out(sb_hs), .vsync_out(sb_vs),
    .active_draw_out(sb_ad), .buffer_sel(sb_sel), .frame_done(sb_done),
    .write_count(sb_count)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic db_write(input int h, input int v, input logic [23:0] d, input logic nf);
    db_if.s_pixel_tdata  = d;
    db_if.s_hcount       = 11'(h);
    db_if.s_vcount       = 10'(v);
    db_if.s_pixel_tvalid = 1'b1;
    new_frame_in         = nf;
    tick();
    db_if.s_pixel_tvalid = 1'b0;
    new_frame_in         = 1'b0;
  endtask

  task automatic sb_write(input int h, input int v, input logic [23:0] d);
    sb_if.s_pixel_tdata  = d;
    sb_if.s_hcount       = 11'(h);
    sb_if.s_vcount       = 10'(v);
    sb_if.s_pixel_tvalid = 1'b1;
    tick();
    sb_if.s_pixel_tvalid = 1'b0;
  endtask

  task automatic pulse_nf();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic scan(input int h, input int v, input logic act);
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    active_draw_in = act;
    tick();
    tick();
  endtask

  logic [2:0] pat [6] = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b000, 3'b101};
  logic [2:0] prev_pat;

  initial begin
    db_if.s_pixel_tdata = '0; db_if.s_pixel_tvalid = 1'b0; db_if.s_hcount = '0; db_if.s_vcount = '0;
    sb_if.s_pixel_tdata = '0; sb_if.s_pixel_tvalid = 1'b0; sb_if.s_hcount = '0; sb_if.s_vcount = '0;

    // Power-on reset
    #1 aresetn = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(db_count), 0);
    chk("rst_tready", 32'(db_if.s_pixel_tready), 1);
    chk("rst_sel", 32'(db_sel), 0);
    chk("rst_done", 32'(db_done), 0);
    chk("rst_pixel", 32'(db_pixel), 0);
    @(negedge aclk) aresetn = 1'b1;
    tick();

    // Reset mid-fill: 3 writes with sync outputs driven high, then async reset
    hsync_in = 1'b1; vsync_in = 1'b1; active_draw_in = 1'b1;
    hcount_in = 11'd12; vcount_in = 10'd6;
    for (int a = 0; a < 3; a++) db_write(10 + a, 5, 24'(a), 1'b0);
    chk("mid_count_pre", 32'(db_count), 3);
    chk("mid_sync_pre", 32'({db_hs, db_vs, db_ad}), 3'b111);
    aresetn = 1'b0;
    #2;
    chk("mid_count", 32'(db_count), 0);
    chk("mid_tready", 32'(db_if.s_pixel_tready), 1);
    chk("mid_sync", 32'({db_hs, db_vs, db_ad}), 0);
    chk("mid_pixel", 32'(db_pixel), 0);
    chk("mid_sel_done", 32'({db_sel, db_done}), 0);
    hsync_in = 1'b0; vsync_in = 1'b0; active_draw_in = 1'b0;
    @(negedge aclk) aresetn = 1'b1;
    tick();

    // Fill back bank (bank 1) with data = offset, then swap
    for (int a = 0; a < 7; a++) db_write(10 + (a % 4), 5 + (a / 4), 24'(a), 1'b0);
    chk("fill_count7", 32'(db_count), 7);
    chk("fill_tready7", 32'(db_if.s_pixel_tready), 1);
    db_write(13, 6, 24'd7, 1'b0);
    chk("fill_count8", 32'(db_count), 8);
    chk("fill_tready8", 32'(db_if.s_pixel_tready), 0);
    tick();
    chk("fill_wait_sel", 32'({db_sel, db_done}), 2'b00);
    pulse_nf();
    chk("swap_sel", 32'(db_sel), 1);
    chk("swap_done", 32'(db_done), 1);
    chk("swap_count", 32'(db_count), 0);
    chk("swap_tready", 32'(db_if.s_pixel_tready), 1);
    tick();
    chk("swap_done_clr", 32'(db_done), 0);

    scan(12, 6, 1'b1);
    chk("scan_12_6", 32'(db_pixel), 6);
    scan(13, 5, 1'b1);
    chk("scan_13_5", 32'(db_pixel), 3);
    scan(9, 6, 1'b1);
    chk("scan_9_6_bg", 32'(db_pixel), 32'(BG));
    scan(12, 6, 1'b0);
    chk("scan_inactive_bg", 32'(db_pixel), 32'(BG));

    // Out-of-region pixels are accepted and dropped
    db_write(9, 5, 24'hEE, 1'b0);
    db_write(14, 6, 24'hEE, 1'b0);
    db_write(11, 7, 24'hEE, 1'b0);
    db_write(10, 4, 24'hEE, 1'b0);
    chk("drop_count", 32'(db_count), 0);

    // Fill bank 0 with 0x40+offset; completing write coincides with new_frame_in
    for (int a = 0; a < 7; a++) db_write(10 + (a % 4), 5 + (a / 4), 24'h40 + 24'(a), 1'b0);
    chk("coin_count7", 32'(db_count), 7);
    db_write(13, 6, 24'h47, 1'b1);
    chk("coin_count8", 32'(db_count), 8);
    chk("coin_no_swap", 32'({db_sel, db_done}), 2'b10);
    chk("coin_tready", 32'(db_if.s_pixel_tready), 0);
    db_write(10, 5, 24'hFF, 1'b0);
    chk("bp_count", 32'(db_count), 8);
    chk("bp_sel", 32'(db_sel), 1);
    pulse_nf();
    chk("coin_swap_sel", 32'(db_sel), 0);
    chk("coin_swap_done", 32'(db_done), 1);
    tick();
    chk("coin_done_clr", 32'(db_done), 0);
    scan(12, 6, 1'b1);
    chk("coin_scan_12_6", 32'(db_pixel), 32'h46);
    scan(10, 5, 1'b1);
    chk("bp_scan_10_5", 32'(db_pixel), 32'h40);

    // Sync/active alignment: outputs follow inputs exactly 2 cycles later
    active_draw_in = 1'b0;
    tick(); tick();
    prev_pat = 3'b000;
    for (int i = 0; i < 6; i++) begin
      {hsync_in, vsync_in, active_draw_in} = pat[i];
      tick();
      chk("sync_align", 32'({db_hs, db_vs, db_ad}), 32'(prev_pat));
      prev_pat = pat[i];
    end
    {hsync_in, vsync_in, active_draw_in} = 3'b000;
    tick();
    chk("sync_align_last", 32'({db_hs, db_vs, db_ad}), 32'(prev_pat));

    // Single-bank mode: 10 writes, frame_done after the 8th, count wraps to 2
    for (int k = 0; k < 10; k++) begin
      chk("sb_tready", 32'(sb_if.s_pixel_tready), 1);
      sb_write(10 + ((k % 8) % 4), 5 + ((k % 8) / 4), 24'h200 + 24'(k));
      if (k == 7) begin
        chk("sb_done_pulse", 32'(sb_done), 1);
        chk("sb_wrap", 32'(sb_count), 0);
      end else begin
        chk("sb_done_idle", 32'(sb_done), 0);
      end
    end
    chk("sb_count_end", 32'(sb_count), 2);
    chk("sb_sel", 32'(sb_sel), 0);
    scan(11, 5, 1'b1);
    chk("sb_scan_11_5", 32'(sb_pixel), 32'h209);
    chk("db_scan_11_5", 32'(db_pixel), 32'h41);
    scan(12, 6, 1'b1);
    chk("sb_scan_12_6", 32'(sb_pixel), 32'h206);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
